// File: rtl/riscv_data_responder.sv
// riscv_data_responder
//   Data-side responder for a small RISC-V core: a word-organised data RAM
//   mapped from address 0 plus a three-register timer/status window.
//
//   Parameters
//     RAM_WORDS  : data RAM depth in 32-bit words, mapped at 0x0000_0000
//     TIMER_BASE : base of the register window
//                  +0 MTIME, +4 MTIMECMP, +8 STATUS {MISALIGN, PENDING} (W1C)
//
//   Ports
//     clock, reset     : single clock, synchronous active-high reset
//     data_address     : byte address from the core
//     data_width       : 0 byte, 1 half, 2 word, 3 idle
//     data_read/write  : load / store request this cycle
//     data_write_value : store data, right-aligned
//     data_read_value  : load data, right-aligned, zero-extended (combinational)
//     irq              : timer interrupt, equal to the registered PENDING bit
//
//   Build option
//     TIMER_IRQ_EN : when defined, MTIME/MTIMECMP/PENDING are implemented.
//                    When undefined they read 0, ignore writes and irq is 0.
//
//   Alignment is checked for every active access, whatever it maps to.
//   The read value is driven for any active access (load, store or both),
//   so a combined load/store returns the pre-store contents.
module riscv_data_responder #(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] TIMER_BASE = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic [1:0]  data_width,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_write_value,
  output logic [31:0] data_read_value,
  output logic        irq
);

  localparam int AW = $clog2(RAM_WORDS);

  // Byte-lane organised RAM, never reset.
  logic [3:0][7:0] mem [RAM_WORDS];

  logic          active, misal, in_ram, do_wr;
  logic          hit_time, hit_cmp, hit_stat, reg_word;
  logic [AW-1:0] widx;
  logic [31:0]   ram_word, ram_shift, ram_rd, reg_rd;
  logic [3:0]    be_base, be;
  logic [31:0]   wdat;
  logic          ram_we, wr_stat;

  logic          misalign_d, misalign_q;
  logic          pending;
  logic [31:0]   mtime_rd, mtimecmp_rd;

  // ---------------------------------------------------------------- decode
  always_comb begin
    active   = (data_read | data_write) & (data_width != 2'd3);
    misal    = active & (((data_width == 2'd1) & data_address[0]) |
                         ((data_width == 2'd2) & (data_address[1:0] != 2'b00)));
    in_ram   = data_address[31:2] < 30'(RAM_WORDS);
    widx     = data_address[AW+1:2];
    hit_time = data_address == TIMER_BASE;
    hit_cmp  = data_address == TIMER_BASE + 32'd4;
    hit_stat = data_address == TIMER_BASE + 32'd8;
    // Registers answer only to full-word accesses; anything narrower in the
    // window falls through to the "unmapped" zero read.
    reg_word = data_width == 2'd2;
    do_wr    = active & data_write & ~misal;
  end

  // ------------------------------------------------------------- read path
  always_comb begin
    ram_word  = mem[widx];
    ram_shift = ram_word >> {data_address[1:0], 3'b000};
    case (data_width)
      2'd0:    ram_rd = {24'b0, ram_shift[7:0]};
      2'd1:    ram_rd = {16'b0, ram_shift[15:0]};
      default: ram_rd = ram_shift;
    endcase

    reg_rd = '0;
    if (reg_word) begin
      if (hit_time)      reg_rd = mtime_rd;
      else if (hit_cmp)  reg_rd = mtimecmp_rd;
      else if (hit_stat) reg_rd = {30'b0, misalign_q, pending};
    end

    data_read_value = '0;
    if (active && !misal) begin
      if (in_ram) data_read_value = ram_rd;
      else        data_read_value = reg_rd;
    end
  end

  // ------------------------------------------------------------ RAM write
  always_comb begin
    case (data_width)
      2'd0:    be_base = 4'b0001;
      2'd1:    be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
    be     = be_base << data_address[1:0];
    wdat   = data_write_value << {data_address[1:0], 3'b000};
    // A store coincident with reset is dropped.
    ram_we = do_wr & in_ram & ~reset;
  end

  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem[widx][l] <= wdat[8*l +: 8];
      end
    end
  end

  // ------------------------------------------------------------ STATUS
  assign wr_stat = do_wr & ~in_ram & reg_word & hit_stat;

  // Set wins over a same-cycle W1C clear.
  always_comb begin
    misalign_d = (misalign_q & ~(wr_stat & data_write_value[1])) | misal;
  end

  always_ff @(posedge clock) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

`ifdef TIMER_IRQ_EN
  // ------------------------------------------------------------ timer
  logic [31:0] mtime_d, mtime_q, mtimecmp_d, mtimecmp_q;
  logic        pending_d, pending_q;
  logic        wr_time, wr_cmp, cmp_hit;

  always_comb begin
    wr_time    = do_wr & ~in_ram & reg_word & hit_time;
    wr_cmp     = do_wr & ~in_ram & reg_word & hit_cmp;
    cmp_hit    = mtime_q == mtimecmp_q;
    mtime_d    = wr_time ? data_write_value : mtime_q + 32'd1;
    mtimecmp_d = wr_cmp ? data_write_value : mtimecmp_q;
    // Compare is on registered values, so PENDING lands the edge after the
    // match; a MTIMECMP write never clears it.
    pending_d  = (pending_q & ~(wr_stat & data_write_value[0])) | cmp_hit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mtime_q    <= 32'h0;
      mtimecmp_q <= 32'hFFFF_FFFF;
      pending_q  <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      pending_q  <= pending_d;
    end
  end

  assign mtime_rd    = mtime_q;
  assign mtimecmp_rd = mtimecmp_q;
  assign pending     = pending_q;
  assign irq         = pending_q;
`else
  assign mtime_rd    = 32'h0;
  assign mtimecmp_rd = 32'h0;
  assign pending     = 1'b0;
  assign irq         = 1'b0;
`endif

endmodule
